// File: rtl/press_pkg.sv
// Shared constants for the press classifier: FSM state encoding and parameter defaults.
package press_pkg;

  localparam int unsigned CNT_W_DEF      = 24;
  localparam int unsigned LONG_TICKS_DEF = 50000;
  localparam int unsigned DBL_TICKS_DEF  = 25000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HELD      = 3'd1;
  localparam logic [2:0] ST_GAP       = 3'd2;
  localparam logic [2:0] ST_HELD2     = 3'd3;
  localparam logic [2:0] ST_LONG_HOLD = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on clr and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/press_classifier.sv
// Turns edge-detector pulses into short/double/long press events and measures each press length.
module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned      CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] LONG_TICKS = CNT_W'(LONG_TICKS_DEF),
  parameter logic [CNT_W-1:0] DBL_TICKS  = CNT_W'(DBL_TICKS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pos_edge,
  input  logic             neg_edge,
  output logic             short_press,
  output logic             double_press,
  output logic             long_press,
  output logic [CNT_W-1:0] press_len,
  output logic             len_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_TICKS - CNT_W'(1);
  localparam logic [CNT_W-1:0] DBL_LAST  = DBL_TICKS - CNT_W'(1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_inc;
  logic             pos, neg;
  logic             short_nxt, double_nxt, long_nxt, len_vld_nxt;
  logic [CNT_W-1:0] len_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Simultaneous edges carry no usable direction, so both are dropped.
  assign pos = pos_edge & ~neg_edge;
  assign neg = neg_edge & ~pos_edge;

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt)
  );

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_inc     = (state != ST_IDLE);
    short_nxt   = 1'b0;
    double_nxt  = 1'b0;
    long_nxt    = 1'b0;
    len_vld_nxt = 1'b0;
    len_nxt     = press_len;
    case (state)
      ST_IDLE: begin
        if (pos) begin
          state_nxt = ST_HELD;
          cnt_clr   = 1'b1;
        end
      end
      ST_HELD: begin
        if (neg) begin
          len_nxt     = sat_inc(cnt);
          len_vld_nxt = 1'b1;
          state_nxt   = ST_GAP;
          cnt_clr     = 1'b1;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = ST_LONG_HOLD;
        end
      end
      ST_GAP: begin
        if (pos) begin
          state_nxt = ST_HELD2;
          cnt_clr   = 1'b1;
        end else if (cnt == DBL_LAST) begin
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HELD2: begin
        // A held second press still counts as a double, never as a long press.
        if (neg) begin
          len_nxt     = sat_inc(cnt);
          len_vld_nxt = 1'b1;
          double_nxt  = 1'b1;
          state_nxt   = ST_IDLE;
        end else if (cnt == LONG_LAST) begin
          double_nxt = 1'b1;
          state_nxt  = ST_LONG_HOLD;
        end
      end
      ST_LONG_HOLD: begin
        if (neg) begin
          len_nxt     = sat_inc(cnt);
          len_vld_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      len_valid    <= 1'b0;
      press_len    <= '0;
    end else begin
      state        <= state_nxt;
      short_press  <= short_nxt;
      double_press <= double_nxt;
      long_press   <= long_nxt;
      len_valid    <= len_vld_nxt;
      press_len    <= len_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: directed timing scenarios plus randomized edges against a timestamp model.
module tb_press_classifier;

  localparam int CW     = 5;
  localparam int L      = 8;
  localparam int D      = 5;
  localparam int MAXLEN = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pos_edge;
  logic          neg_edge;
  logic          short_press;
  logic          double_press;
  logic          long_press;
  logic [CW-1:0] press_len;
  logic          len_valid;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  press_classifier #(
    .CNT_W      (CW),
    .LONG_TICKS (CW'(L)),
    .DBL_TICKS  (CW'(D))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pos_edge     (pos_edge),
    .neg_edge     (neg_edge),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .press_len    (press_len),
    .len_valid    (len_valid),
    .busy         (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Timestamp model: a press is described by when it started, when it was
  // released, whether it is the second press and whether it already went long.
  bit m_pressed = 0, m_wait = 0, m_second = 0, m_long = 0;
  int t_press = 0, t_rel = 0;
  bit e_short = 0, e_double = 0, e_long = 0, e_vld = 0, e_busy = 0;
  int e_len = 0;

  initial begin
    forever begin
      bit p, n;
      @(negedge clk);
      if (cyc > 0) begin
        chk("short_press",  64'(short_press),  64'(e_short));
        chk("double_press", 64'(double_press), 64'(e_double));
        chk("long_press",   64'(long_press),   64'(e_long));
        chk("len_valid",    64'(len_valid),    64'(e_vld));
        chk("press_len",    64'(press_len),    64'(e_len));
        chk("busy",         64'(busy),         64'(e_busy));
      end
      p = pos_edge && !neg_edge;
      n = neg_edge && !pos_edge;
      e_short = 0; e_double = 0; e_long = 0; e_vld = 0;
      if (!rst) begin
        m_pressed = 0; m_wait = 0; m_second = 0; m_long = 0; e_len = 0;
      end else if (m_pressed) begin
        if (n) begin
          e_vld = 1;
          e_len = (cyc - t_press > MAXLEN) ? MAXLEN : cyc - t_press;
          if (m_second && !m_long) e_double = 1;
          if (!m_second && !m_long) begin
            m_wait = 1;
            t_rel  = cyc;
          end
          m_pressed = 0;
        end else if (!m_long && (cyc - t_press == L)) begin
          m_long = 1;
          if (m_second) e_double = 1;
          else          e_long   = 1;
        end
      end else if (m_wait) begin
        if (p) begin
          m_wait = 0; m_pressed = 1; m_second = 1; m_long = 0; t_press = cyc;
        end else if (cyc - t_rel == D) begin
          e_short = 1;
          m_wait  = 0;
        end
      end else if (p) begin
        m_pressed = 1; m_second = 0; m_long = 0; t_press = cyc;
      end
      e_busy = m_pressed || m_wait;
      cyc++;
    end
  end

  // Directed scenario recording: bit k of each mask is the output in scenario cycle k.
  int pos_q[$];
  int neg_q[$];
  logic [63:0] ob_short, ob_double, ob_long, ob_vld, ob_busy;
  int ob_len [64];

  function automatic bit has(input int q[$], input int k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] at(input int c);
    logic [63:0] one;
    one = 64'd1;
    return one << c;
  endfunction

  task automatic run_case(input int ncyc, input int rst_at);
    rst = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ob_short = '0; ob_double = '0; ob_long = '0; ob_vld = '0; ob_busy = '0;
    for (int i = 0; i < 64; i++) ob_len[i] = 0;
    for (int k = 0; k < ncyc; k++) begin
      rst      = (k == rst_at) ? 1'b0 : 1'b1;
      pos_edge = has(pos_q, k);
      neg_edge = has(neg_q, k);
      @(posedge clk); #1;
      if (k + 1 < 64) begin
        ob_short[k+1]  = short_press;
        ob_double[k+1] = double_press;
        ob_long[k+1]   = long_press;
        ob_vld[k+1]    = len_valid;
        ob_busy[k+1]   = busy;
        ob_len[k+1]    = int'(press_len);
      end
    end
    pos_edge = 1'b0; neg_edge = 1'b0; rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0;

    pos_q = {10}; neg_q = {13};
    run_case(25, -1);
    chk("short.vld",    ob_vld, at(14));
    chk("short.len",    64'(ob_len[14]), 64'd3);
    chk("short.short",  ob_short, at(19));
    chk("short.double", ob_double, 64'd0);
    chk("short.long",   ob_long, 64'd0);

    pos_q = {10, 15}; neg_q = {12, 18};
    run_case(30, -1);
    chk("double.vld",    ob_vld, at(13) | at(19));
    chk("double.len1",   64'(ob_len[13]), 64'd2);
    chk("double.len2",   64'(ob_len[19]), 64'd3);
    chk("double.double", ob_double, at(19));
    chk("double.short",  ob_short, 64'd0);

    pos_q = {10}; neg_q = {30};
    run_case(40, -1);
    chk("long.long",  ob_long, at(19));
    chk("long.vld",   ob_vld, at(31));
    chk("long.len",   64'(ob_len[31]), 64'd20);
    chk("long.short", ob_short, 64'd0);

    pos_q = {10, 17}; neg_q = {12, 19};
    run_case(30, -1);
    chk("gap17.double", ob_double, at(20));
    chk("gap17.len",    64'(ob_len[20]), 64'd2);
    chk("gap17.short",  ob_short, 64'd0);

    pos_q = {10, 18}; neg_q = {12, 20};
    run_case(32, -1);
    chk("gap18.short",  ob_short, at(18) | at(26));
    chk("gap18.vld",    ob_vld, at(13) | at(21));
    chk("gap18.double", ob_double, 64'd0);
    chk("gap18.busy",   64'(ob_busy[19:18]), 64'd2);

    pos_q = {10}; neg_q = {14};
    run_case(25, 12);
    chk("rst.vld",      ob_vld, 64'd0);
    chk("rst.pulses",   ob_short | ob_double | ob_long, 64'd0);
    chk("rst.busy_pre", 64'(ob_busy[11]), 64'd1);
    chk("rst.busy",     ob_busy >> 13, 64'd0);
    chk("rst.len",      64'(ob_len[20]), 64'd0);

    pos_q = {7}; neg_q = {5, 7};
    run_case(20, -1);
    chk("stray.pulses", ob_short | ob_double | ob_long | ob_vld, 64'd0);
    chk("stray.busy",   ob_busy, 64'd0);

    pos_q = {2}; neg_q = {40};
    run_case(50, -1);
    chk("sat.long", ob_long, at(11));
    chk("sat.vld",  ob_vld, at(41));
    chk("sat.len",  64'(ob_len[41]), 64'(MAXLEN));

    pos_q = {2, 6}; neg_q = {4, 20};
    run_case(30, -1);
    chk("held2.double", ob_double, at(15));
    chk("held2.long",   ob_long, 64'd0);
    chk("held2.vld",    ob_vld, at(5) | at(21));
    chk("held2.len",    64'(ob_len[21]), 64'd14);
    chk("held2.short",  ob_short, 64'd0);

    for (int blk = 0; blk < 12; blk++) begin
      int pp;
      pp = 3 + (blk % 6) * 5;
      for (int k = 0; k < 250; k++) begin
        rst      = ($urandom_range(0, 299) != 0);
        pos_edge = ($urandom_range(0, 99) < pp);
        neg_edge = ($urandom_range(0, 99) < pp);
        @(posedge clk); #1;
      end
    end

    rst = 1'b1; pos_edge = 1'b0; neg_edge = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
